// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu core and its RAM arbiter: default widths,
// starvation limit and the encoding of the in-flight read tag.
package cpu_pkg;

  localparam int AW_DEF       = 8;
  localparam int DW_DEF       = 16;
  localparam int MAX_WAIT_DEF = 3;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_IF   = 2'd1,
    TAG_D    = 2'd2
  } tag_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied cycles for one requester; raises
// force_win once the requester has waited MAX_WAIT cycles in a row.
module arb_starve_ctr
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req,
  input  logic gnt,
  output logic force_win
);

  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [WW-1:0] cnt_reg;

  assign force_win = (cnt_reg == WW'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (!req || gnt) begin
      cnt_reg <= '0;
    end else if (!force_win) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between instruction fetch and load/store.
// Data wins contention unless fetch has starved; read data is steered back one cycle later.
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic [DW-1:0] if_rdata,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic [DW-1:0] d_rdata,
  output logic          d_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [CW-1:0] conflict_cnt
);

  logic          force_if;
  tag_e          tag_reg;
  tag_e          tag_next;
  logic [DW-1:0] if_rdata_reg;
  logic [DW-1:0] d_rdata_reg;
  logic [CW-1:0] conflict_reg;

  arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_if_starve (
    .clk       (clk),
    .reset     (reset),
    .req       (if_req),
    .gnt       (if_gnt),
    .force_win (force_if)
  );

  // Reset suppresses grants so nothing reaches the RAM during the reset cycle.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && d_req) begin
        if (force_if) if_gnt = 1'b1;
        else          d_gnt  = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | d_gnt;
    mem_we    = d_gnt & d_we;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_gnt) begin
      mem_addr = if_addr;
    end else if (d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  always_comb begin
    tag_next = TAG_NONE;
    if (if_gnt)             tag_next = TAG_IF;
    else if (d_gnt && !d_we) tag_next = TAG_D;
  end

  // RAM data is only valid in the cycle after the read; the hold registers
  // keep each side's last returned word stable between its own reads.
  assign if_rvalid = !reset && (tag_reg == TAG_IF);
  assign d_rvalid  = !reset && (tag_reg == TAG_D);
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_reg;
  assign d_rdata   = d_rvalid  ? mem_rdata : d_rdata_reg;
  assign conflict_cnt = conflict_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_reg      <= TAG_NONE;
      if_rdata_reg <= '0;
      d_rdata_reg  <= '0;
      conflict_reg <= '0;
    end else begin
      tag_reg <= tag_next;
      if (if_rvalid) if_rdata_reg <= mem_rdata;
      if (d_rvalid)  d_rdata_reg  <= mem_rdata;
      if (if_req && d_req && (conflict_reg != '1)) conflict_reg <= conflict_reg + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Vector-driven bench for ram_arbiter: per-cycle grant/RAM checks from a table,
// read returns checked through a scoreboard queue against a reference memory.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 16;

  typedef struct {
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          eif;
    logic          ed;
  } vec_t;

  typedef struct {
    logic          is_if;
    logic [DW-1:0] data;
  } ret_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, d_req, d_we;
  logic [AW-1:0] if_addr, d_addr;
  logic [DW-1:0] d_wdata;
  logic          if_gnt, if_rvalid, d_gnt, d_rvalid;
  logic [DW-1:0] if_rdata, d_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [15:0]   conflict_cnt;

  logic          s_if_gnt, s_if_rvalid, s_d_gnt, s_d_rvalid, s_mem_en, s_mem_we;
  logic [DW-1:0] s_if_rdata, s_d_rdata, s_mem_wdata;
  logic [AW-1:0] s_mem_addr;
  logic [3:0]    s_conflict_cnt;

  logic [DW-1:0] ram     [256];
  logic [DW-1:0] ref_mem [256];
  ret_t          sb[$];
  vec_t          tbl[$];
  logic [DW-1:0] hold_if, hold_d;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(3), .CW(16)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  // Narrow-counter instance sharing the stimulus, used for saturation.
  ram_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(3), .CW(4)) dut_sat (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(s_if_gnt), .if_rdata(s_if_rdata), .if_rvalid(s_if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(s_d_gnt), .d_rdata(s_d_rdata), .d_rvalid(s_d_rvalid),
    .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(s_conflict_cnt)
  );

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ifr, input logic [AW-1:0] ia, input logic dr,
                              input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                              input logic eif, input logic ed);
    vec_t v;
    v.if_req = ifr; v.if_addr = ia; v.d_req = dr; v.d_we = dw;
    v.d_addr = da;  v.d_wdata = wd; v.eif = eif;  v.ed = ed;
    return v;
  endfunction

  task automatic run(input vec_t v, input logic rst);
    logic          e_if, e_d, e_ifv, e_dv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_ifd, e_dd;
    ret_t          r;
    @(negedge clk);
    reset   = rst;
    if_req  = v.if_req;  if_addr = v.if_addr;
    d_req   = v.d_req;   d_we    = v.d_we;
    d_addr  = v.d_addr;  d_wdata = v.d_wdata;
    #2;
    e_if   = !rst && v.eif;
    e_d    = !rst && v.ed;
    e_addr = e_if ? v.if_addr : (e_d ? v.d_addr : '0);
    e_wd   = (e_d && !e_if) ? v.d_wdata : '0;
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("d_gnt", 32'(d_gnt), 32'(e_d));
    chk("mem_en", 32'(mem_en), 32'(e_if | e_d));
    chk("mem_we", 32'(mem_we), 32'(e_d & v.d_we));
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_wdata", 32'(mem_wdata), 32'(e_wd));
    e_ifv = 1'b0; e_dv = 1'b0; e_ifd = hold_if; e_dd = hold_d;
    if (rst) begin
      sb.delete();
    end else if (sb.size() > 0) begin
      r = sb.pop_front();
      if (r.is_if) begin e_ifv = 1'b1; e_ifd = r.data; end
      else         begin e_dv  = 1'b1; e_dd  = r.data; end
    end
    chk("if_rvalid", 32'(if_rvalid), 32'(e_ifv));
    chk("d_rvalid", 32'(d_rvalid), 32'(e_dv));
    chk("if_rdata", 32'(if_rdata), 32'(e_ifd));
    chk("d_rdata", 32'(d_rdata), 32'(e_dd));
    $display("cyc %0d rst=%0d if_req=%0d d_req=%0d we=%0d if_gnt=%0d d_gnt=%0d if_rv=%0d d_rv=%0d if_rdata=%h d_rdata=%h",
             cyc, rst, v.if_req, v.d_req, v.d_we, if_gnt, d_gnt, if_rvalid, d_rvalid, if_rdata, d_rdata);
    if (e_if) begin
      r.is_if = 1'b1; r.data = ref_mem[v.if_addr]; sb.push_back(r);
    end else if (e_d && !v.d_we) begin
      r.is_if = 1'b0; r.data = ref_mem[v.d_addr]; sb.push_back(r);
    end
    if (e_d && v.d_we) ref_mem[v.d_addr] = v.d_wdata;
    if (rst) begin
      hold_if = '0; hold_d = '0;
    end else begin
      hold_if = e_ifd; hold_d = e_dd;
    end
    cyc++;
  endtask

  initial begin
    logic [7:0] pat;
    for (int i = 0; i < 256; i++) begin
      ram[i] = '0; ref_mem[i] = '0;
    end
    ram[0] = 16'h4001; ram[1] = 16'h4400; ram[2] = 16'h8003; ram[3] = 16'hE105;
    ref_mem[0] = 16'h4001; ref_mem[1] = 16'h4400; ref_mem[2] = 16'h8003; ref_mem[3] = 16'hE105;
    mem_rdata = '0;
    hold_if = '0; hold_d = '0;
    reset = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0;

    // Reset held with both requesters active.
    run(mk(1'b1, 8'h00, 1'b1, 1'b0, 8'h07, 16'h0, 1'b0, 1'b0), 1'b1);
    run(mk(1'b1, 8'h00, 1'b1, 1'b0, 8'h07, 16'h0, 1'b0, 1'b0), 1'b1);
    chk("conflict_rst", 32'(conflict_cnt), 32'd0);

    // Fetch stream, store then load, idle to drain.
    for (int a = 0; a < 4; a++) tbl.push_back(mk(1'b1, 8'(a), 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 8'h05, 16'hBEEF, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 8'h05, 16'h0000, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0));
    // Contention: expected winners D,D,D,IF,D,D,D,IF (bit set = fetch wins).
    pat = 8'b1000_1000;
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(1'b1, 8'(i / 4), 1'b1, 1'b0, 8'h05, 16'h0, pat[i], !pat[i]));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0));
    foreach (tbl[i]) run(tbl[i], 1'b0);
    chk("conflict_8", 32'(conflict_cnt), 32'd8);

    // Fetch read granted, then reset the next cycle: no return after reset.
    run(mk(1'b1, 8'h02, 1'b0, 1'b0, 8'h00, 16'h0, 1'b1, 1'b0), 1'b0);
    run(mk(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0), 1'b1);
    run(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0), 1'b0);
    chk("conflict_after_rst", 32'(conflict_cnt), 32'd0);
    chk("sat_after_rst", 32'(s_conflict_cnt), 32'd0);

    // 20 contended cycles: the 4-bit counter must stop at 15.
    for (int i = 0; i < 20; i++)
      run(mk(1'b1, 8'(i / 4), 1'b1, 1'b0, 8'h05, 16'h0, (i % 4) == 3, (i % 4) != 3), 1'b0);
    run(mk(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0), 1'b0);
    chk("sat_cnt", 32'(s_conflict_cnt), 32'd15);
    chk("conflict_20", 32'(conflict_cnt), 32'd20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port program/data RAM between the CPU instruction-fetch path and the load/store data path.
- Arbitrates one access per cycle:
  - data side has priority;
  - a starvation counter guarantees fetch progress.
- Tracks in-flight reads and steers RAM read data back to the owning requester one cycle later.
- Sits between the cpu core (PC/fetch and execute stages) and the RAM instance.

Parameters:
- AW, 8, RAM address width (matches 8-bit immediate/address field).
- DW, 16, RAM data/instruction width.
- MAX_WAIT, 3, consecutive denied fetch cycles before fetch is forced to win.
- CW, 16, width of saturating conflict counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  fetch read request.
- if_addr  in  AW  fetch address (PC).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rdata  out  DW  fetched instruction.
- if_rvalid  out  1  if_rdata valid (1 cycle after grant).
- d_req  in  1  data access request.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rdata  out  DW  load data.
- d_rvalid  out  1  d_rdata valid (1 cycle after granted load).
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after mem_en && !mem_we.
- conflict_cnt  out  CW  saturating count of cycles with both requests active.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high. All state updates on rising clk.
- Reset values:
  - owner/pending registers cleared; wait counter 0; conflict_cnt 0;
  - all gnt/rvalid outputs 0;
  - mem_en and mem_we 0 during the reset cycle (reset overrides requests).
- Grant is combinational from the current-cycle requests and the registered wait counter:
  - only d_req → d_gnt=1.
  - only if_req → if_gnt=1.
  - both, wait_cnt < MAX_WAIT → d_gnt=1, if_gnt=0.
  - both, wait_cnt == MAX_WAIT → if_gnt=1, d_gnt=0.
  - at most one gnt high per cycle; neither request → mem_en=0.
- RAM drive:
  - mem_en = if_gnt | d_gnt.
  - mem_we = d_gnt & d_we; a fetch never writes.
  - mem_addr and mem_wdata come from the granted side; when idle they hold 0.
- Read return:
  - a registered pending tag (none/fetch/data) is set on a granted read.
  - next cycle: if_rvalid or d_rvalid = 1 for exactly one cycle, with the corresponding rdata = mem_rdata.
  - the non-owner rvalid stays 0 and its rdata holds its last value.
  - stores produce no rvalid.
- Throughput: back-to-back grants allowed every cycle; a new grant may coincide with the rvalid of the previous read.
- Requester rule: a requester keeps req, addr, we and wdata stable until it sees gnt. A request is consumed in its gnt cycle.
- Wait counter:
  - increments when if_req && !if_gnt, saturating at MAX_WAIT.
  - cleared on if_gnt or when if_req = 0.
- conflict_cnt: +1 each cycle with if_req && d_req; saturates at all-ones (no wrap).
- Reset mid-operation: a read granted in the cycle reset asserts, or the cycle before, produces no rvalid after reset; the pending tag is cleared.
- Address wrap: none inside the block; addresses pass through unmodified at AW bits.

Decomposition:
- Shared package cpu_pkg:
  - AW/DW defaults;
  - the pending-tag encoding (TAG_NONE=0, TAG_IF=1, TAG_D=2);
  - MAX_WAIT default.
- One natural sub-module: arb_starve_ctr, the saturating wait counter plus force flag, reused for future requesters.
- The grant mux and return steering stay in ram_arbiter.

Test Plan:
- Reset hold (reset=1 for 2 cycles, both req=1) → mem_en=0, if_gnt=d_gnt=0, conflict_cnt=0, no rvalid.
- Fetch only (if_req=1, if_addr=0..3, RAM preloaded 0x4001,0x4400,0x8003,0xE105) → if_gnt every cycle; if_rvalid from cycle 2 with if_rdata 0x4001,0x4400,0x8003,0xE105 in order.
- Data store then load (d_we=1 addr 0x05 data 0xBEEF; then d_we=0 addr 0x05) → mem_we=1 on the first, no rvalid; d_rvalid=1 with d_rdata=0xBEEF on the cycle after the load grant.
- Contention (if_req=d_req=1 for 8 cycles, MAX_WAIT=3) → grants D,D,D,IF,D,D,D,IF; conflict_cnt=8; never two gnts in one cycle.
- Reset mid-read (fetch read granted at addr 0x02, reset asserted next cycle) → if_rvalid stays 0; all outputs return to reset values.
- Saturation (CW=4, 20 contended cycles) → conflict_cnt stops at 15.
